// File: rtl/fp_mul_pkg.sv
// Shared definitions for the pipelined floating-point multiplier.
// Contents: operand classes, flag bit positions, rounding modes and the
// exponent-bias helper used to size lane constants.
package fp_mul_pkg;

  // Operand class produced while unpacking an input.
  typedef enum logic [2:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_e;

  // Rounding mode, captured with the operands.
  typedef enum logic {
    RM_RNE = 1'b0,
    RM_RTZ = 1'b1
  } rm_e;

  // Bit positions inside the 4-bit flag word {invalid,overflow,underflow,inexact}.
  localparam int FLAG_W  = 4;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_mul_lane.sv
// One floating-point multiplier lane, three registered stages.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears every register)
//   en          advance enable; when low every stage holds its contents
//   a, b        operands {sign, exponent, stored mantissa}
//   rm          rounding mode (0 = nearest-even, 1 = toward zero)
//   result      registered product
//   flags       registered {invalid, overflow, underflow, inexact}
module fp_mul_lane
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   rm,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [FLAG_W-1:0]      flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW2 = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;
  localparam logic signed [EW2-1:0] BIAS  = EW2'(bias(EXP_W));
  localparam logic signed [EW2-1:0] EMAX  = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] EZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic fp_class_e classify(input logic [W-1:0] x);
    if (x[W-2:MAN_W] == '0) return FP_ZERO;  // subnormals flushed here
    if (x[W-2:MAN_W] != '1) return FP_NORM;
    if (x[MAN_W-1:0] == '0) return FP_INF;
    return x[MAN_W-1] ? FP_QNAN : FP_SNAN;
  endfunction

  function automatic logic [MAN_W+1:0] round_mant(input logic [MAN_W:0] kept,
                                                   input logic g, input logic s,
                                                   input rm_e mode);
    logic up;
    up = (mode == RM_RNE) && g && (s || kept[0]);
    return {1'b0, kept} + {{(MAN_W+1){1'b0}}, up};
  endfunction

  // Range check after rounding: saturate high (inf or max finite) or flush low.
  function automatic logic [FLAG_W+W-1:0] sat_pack(input logic sign,
                                                   input logic signed [EW2-1:0] e,
                                                   input logic [MAN_W-1:0] m,
                                                   input rm_e mode, input logic inexact);
    logic [W-1:0]      r;
    logic [FLAG_W-1:0] f;
    f = '0;
    f[FLG_INX] = inexact;
    if (e >= EMAX) begin
      f[FLG_OVF] = 1'b1;
      f[FLG_INX] = 1'b1;
      r = (mode == RM_RTZ) ? {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                           : {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (e <= EZERO) begin
      f[FLG_UNF] = 1'b1;
      f[FLG_INX] = 1'b1;
      r = {sign, {(W-1){1'b0}}};
    end else begin
      r = {sign, e[EXP_W-1:0], m};
    end
    return {f, r};
  endfunction

  // ---- stage 1: unpack, classify, resolve specials, exponent sum ----
  fp_class_e               ca_p0, cb_p0;
  logic                    sign_p0;
  logic signed [EW2-1:0]   exp_p0;
  logic                    spec_p0;
  logic [W-1:0]            spec_res_p0;
  logic [FLAG_W-1:0]       spec_flg_p0;

  always_comb begin
    ca_p0       = classify(a);
    cb_p0       = classify(b);
    sign_p0     = a[W-1] ^ b[W-1];
    exp_p0      = $signed({2'b00, a[W-2:MAN_W]}) + $signed({2'b00, b[W-2:MAN_W]}) - BIAS;
    spec_p0     = 1'b1;
    spec_res_p0 = '0;
    spec_flg_p0 = '0;
    if (ca_p0 inside {FP_QNAN, FP_SNAN} || cb_p0 inside {FP_QNAN, FP_SNAN}) begin
      spec_res_p0          = QNAN;
      spec_flg_p0[FLG_INV] = (ca_p0 == FP_SNAN) || (cb_p0 == FP_SNAN);
    end else if ((ca_p0 == FP_INF && cb_p0 == FP_ZERO) ||
                 (ca_p0 == FP_ZERO && cb_p0 == FP_INF)) begin
      spec_res_p0          = QNAN;
      spec_flg_p0[FLG_INV] = 1'b1;
    end else if (ca_p0 == FP_INF || cb_p0 == FP_INF) begin
      spec_res_p0 = {sign_p0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (ca_p0 == FP_ZERO || cb_p0 == FP_ZERO) begin
      spec_res_p0 = {sign_p0, {(W-1){1'b0}}};
    end else begin
      spec_p0 = 1'b0;
    end
  end

  logic                  sign_p1, spec_p1;
  logic signed [EW2-1:0] exp_p1;
  logic [MAN_W:0]        ma_p1, mb_p1;
  rm_e                   rm_p1;
  logic [W-1:0]          spec_res_p1;
  logic [FLAG_W-1:0]     spec_flg_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_p1     <= 1'b0;
      spec_p1     <= 1'b0;
      exp_p1      <= '0;
      ma_p1       <= '0;
      mb_p1       <= '0;
      rm_p1       <= RM_RNE;
      spec_res_p1 <= '0;
      spec_flg_p1 <= '0;
    end else if (en) begin
      sign_p1     <= sign_p0;
      spec_p1     <= spec_p0;
      exp_p1      <= exp_p0;
      ma_p1       <= {1'b1, a[MAN_W-1:0]};
      mb_p1       <= {1'b1, b[MAN_W-1:0]};
      rm_p1       <= rm_e'(rm);
      spec_res_p1 <= spec_res_p0;
      spec_flg_p1 <= spec_flg_p0;
    end
  end

  // ---- stage 2: mantissa product and normalisation ----
  // The product is left-aligned instead of shifted right so the bit that a
  // right shift would drop stays available for the sticky OR.
  logic [PW-1:0]         prod_p1, mant_n_p1;
  logic signed [EW2-1:0] exp_n_p1;

  always_comb begin
    prod_p1 = {{(MAN_W+1){1'b0}}, ma_p1} * {{(MAN_W+1){1'b0}}, mb_p1};
    if (prod_p1[PW-1]) begin
      mant_n_p1 = prod_p1;
      exp_n_p1  = exp_p1 + EW2'(1);
    end else begin
      mant_n_p1 = prod_p1 << 1;
      exp_n_p1  = exp_p1;
    end
  end

  logic                  sign_p2, spec_p2;
  logic signed [EW2-1:0] exp_p2;
  logic [PW-1:0]         mant_p2;
  rm_e                   rm_p2;
  logic [W-1:0]          spec_res_p2;
  logic [FLAG_W-1:0]     spec_flg_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_p2     <= 1'b0;
      spec_p2     <= 1'b0;
      exp_p2      <= '0;
      mant_p2     <= '0;
      rm_p2       <= RM_RNE;
      spec_res_p2 <= '0;
      spec_flg_p2 <= '0;
    end else if (en) begin
      sign_p2     <= sign_p1;
      spec_p2     <= spec_p1;
      exp_p2      <= exp_n_p1;
      mant_p2     <= mant_n_p1;
      rm_p2       <= rm_p1;
      spec_res_p2 <= spec_res_p1;
      spec_flg_p2 <= spec_flg_p1;
    end
  end

  // ---- stage 3: round, renormalise, range check, special override ----
  logic                    g_p2, s_p2;
  logic [MAN_W+1:0]        rnd_p2;
  logic [MAN_W-1:0]        m_fin_p2;
  logic signed [EW2-1:0]   e_fin_p2;
  logic [FLAG_W+W-1:0]     out_p2;

  always_comb begin
    g_p2   = mant_p2[MAN_W];
    s_p2   = |mant_p2[MAN_W-1:0];
    rnd_p2 = round_mant(mant_p2[PW-1:MAN_W+1], g_p2, s_p2, rm_p2);
    if (rnd_p2[MAN_W+1]) begin
      m_fin_p2 = rnd_p2[MAN_W:1];
      e_fin_p2 = exp_p2 + EW2'(1);
    end else begin
      m_fin_p2 = rnd_p2[MAN_W-1:0];
      e_fin_p2 = exp_p2;
    end
    out_p2 = spec_p2 ? {spec_flg_p2, spec_res_p2}
                     : sat_pack(sign_p2, e_fin_p2, m_fin_p2, rm_p2, g_p2 | s_p2);
  end

  logic [W-1:0]      res_p3;
  logic [FLAG_W-1:0] flg_p3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_p3 <= '0;
      flg_p3 <= '0;
    end else if (en) begin
      res_p3 <= out_p2[W-1:0];
      flg_p3 <= out_p2[FLAG_W+W-1:W];
    end
  end

  assign result = res_p3;
  assign flags  = flg_p3;

endmodule

// File: rtl/pipe_fp_mul.sv
// Multi-lane pipelined floating-point multiplier (c = a*b), 3-cycle latency.
// Ports:
//   CLK_i, RST_i  clock, asynchronous active-low reset
//   valid_i/ready_o   input handshake for operands_i ({b,a} per lane) and rm_i
//   valid_o/ready_i   output handshake for result_o and flags_o
// All lanes share one handshake; the whole pipe stalls when the output
// register holds data that downstream is not taking.
module pipe_fp_mul
  import fp_mul_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int LANES = 4
) (
  input  logic                                   CLK_i,
  input  logic                                   RST_i,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  input  logic [LANES-1:0][1:0][EXP_W+MAN_W:0]   operands_i,
  input  logic                                   rm_i,
  output logic                                   valid_o,
  input  logic                                   ready_i,
  output logic [LANES-1:0][EXP_W+MAN_W:0]        result_o,
  output logic [LANES-1:0][FLAG_W-1:0]           flags_o
);

  logic vld_p1, vld_p2, vld_p3;
  logic en;

  // A bubble in the last stage lets the pipe advance even without ready_i.
  assign en      = !vld_p3 || ready_i;
  assign ready_o = en;
  assign valid_o = vld_p3;

  always_ff @(posedge CLK_i or negedge RST_i) begin
    if (!RST_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else if (en) begin
      vld_p1 <= valid_i;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fp_mul_lane #(
      .EXP_W(EXP_W),
      .MAN_W(MAN_W)
    ) u_lane (
      .clk   (CLK_i),
      .rst_n (RST_i),
      .en    (en),
      .a     (operands_i[l][0]),
      .b     (operands_i[l][1]),
      .rm    (rm_i),
      .result(result_o[l]),
      .flags (flags_o[l])
    );
  end

endmodule

// File: tb/tb_pipe_fp_mul.sv
// Self-checking bench for pipe_fp_mul (fp16 x4 build).
module tb_pipe_fp_mul;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int LANES = 4;
  localparam int W     = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic valid_i, ready_o, rm, valid_o, ready_i;
  logic [LANES-1:0][1:0][W-1:0] operands;
  logic [LANES-1:0][W-1:0]      result;
  logic [LANES-1:0][3:0]        flags;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [LANES-1:0][W-1:0] res;
    logic [LANES-1:0][3:0]   flg;
  } exp_t;
  exp_t sb_q[$];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        r;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  always #5 clk = ~clk;

  pipe_fp_mul #(.EXP_W(EXP_W), .MAN_W(MAN_W), .LANES(LANES)) dut (
    .CLK_i     (clk),
    .RST_i     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .operands_i(operands),
    .rm_i      (rm),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result),
    .flags_o   (flags)
  );

  // Reference fp16 multiply; returns {flags, result}.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic r);
    int ea, eb, e, sh;
    int unsigned p, q, rem, half;
    logic s, an, bn, ai, bi, az, bz, inx;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    s  = a[15] ^ b[15];
    az = (ea == 0);
    bz = (eb == 0);
    ai = (ea == 31) && (a[9:0] == 10'd0);
    bi = (eb == 31) && (b[9:0] == 10'd0);
    an = (ea == 31) && (a[9:0] != 10'd0);
    bn = (eb == 31) && (b[9:0] != 10'd0);
    if (an || bn) return {((an && !a[9]) || (bn && !b[9])), 3'b000, 16'h7E00};
    if ((ai && bz) || (az && bi)) return {4'b1000, 16'h7E00};
    if (ai || bi) return {4'b0000, s, 15'h7C00};
    if (az || bz) return {4'b0000, s, 15'h0000};
    p = (32'd1024 + 32'(a[9:0])) * (32'd1024 + 32'(b[9:0]));
    e = ea + eb - 15;
    if (p >= 32'h0020_0000) begin
      sh = 11;
      e  = e + 1;
    end else begin
      sh = 10;
    end
    q    = p >> sh;
    rem  = p & ((32'd1 << sh) - 32'd1);
    half = 32'd1 << (sh - 1);
    inx  = (rem != 32'd0);
    if (!r && (rem > half || (rem == half && q[0]))) q = q + 32'd1;
    if (q == 32'd2048) begin
      q = 32'd1024;
      e = e + 1;
    end
    if (e >= 31) return r ? {4'b0101, s, 15'h7BFF} : {4'b0101, s, 15'h7C00};
    if (e <= 0) return {4'b0011, s, 15'h0000};
    return {3'b000, inx, s, e[4:0], q[9:0]};
  endfunction

  function automatic logic [15:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
  endfunction

  // Scoreboard: push on accepted input, pop and compare on delivered output.
  always @(negedge clk) begin
    exp_t        e, got;
    logic [19:0] m;
    if (rst_n) begin
      if (valid_o && ready_i) begin
        got.res = result;
        got.flg = flags;
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got res=%h flg=%h, required no output", result, flags);
        end else begin
          e = sb_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sb_data: got res=%h flg=%h, required res=%h flg=%h",
                     got.res, got.flg, e.res, e.flg);
          end
        end
      end
      if (valid_i && ready_o) begin
        for (int l = 0; l < LANES; l++) begin
          m = model(operands[l][0], operands[l][1], rm);
          e.res[l] = m[15:0];
          e.flg[l] = m[19:16];
        end
        sb_q.push_back(e);
      end
    end
  end

  task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic r);
    @(posedge clk); #1;
    valid_i = 1'b1;
    ready_i = 1'b1;
    rm      = r;
    for (int l = 1; l < LANES; l++) begin
      operands[l][0] = rand_op();
      operands[l][1] = rand_op();
    end
    operands[0][0] = a;
    operands[0][1] = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Waits (bounded) for valid_o; lat=0 means it never came.
  task automatic wait_out(output logic [15:0] r, output logic [3:0] f, output int lat);
    lat = 0;
    r   = '0;
    f   = '0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (valid_o) begin
        r   = result[0];
        f   = flags[0];
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; rm = 1'b0; operands = '0;
    #2;
    checks++;
    if (valid_o !== 1'b0 || result !== '0 || flags !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b res=%h flg=%h, required 0/0/0", valid_o, result, flags);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b valid=%b, required 1/0", ready_o, valid_o);
    end
  endtask

  task automatic test_basic();
    logic [15:0] r; logic [3:0] f; int lat;
    send_one(16'h4000, 16'h4000, 1'b0);
    wait_out(r, f, lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL basic_latency: got %0d, required 3", lat); end
    checks++;
    if (r !== 16'h4400) begin errors++; $display("FAIL basic_result: got %h, required 4400", r); end
    checks++;
    if (f !== 4'h0) begin errors++; $display("FAIL basic_flags: got %h, required 0", f); end
  endtask

  task automatic test_rounding();
    logic [15:0] r; logic [3:0] f; int lat;
    vec_t v[2];
    v[0] = '{16'h3E00, 16'h3C01, 1'b0, 16'h3E02, 4'h1};
    v[1] = '{16'h3E00, 16'h3C01, 1'b1, 16'h3E01, 4'h1};
    for (int i = 0; i < 2; i++) begin
      send_one(v[i].a, v[i].b, v[i].r);
      wait_out(r, f, lat);
      checks++;
      if (lat == 0 || r !== v[i].res || f !== v[i].flg) begin
        errors++;
        $display("FAIL round_%0d: got res=%h flg=%h lat=%0d, required res=%h flg=%h",
                 i, r, f, lat, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_specials();
    logic [15:0] r; logic [3:0] f; int lat;
    vec_t v[7];
    v[0] = '{16'h7C00, 16'h0000, 1'b0, 16'h7E00, 4'h8};
    v[1] = '{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5};
    v[2] = '{16'h7BFF, 16'h7BFF, 1'b1, 16'h7BFF, 4'h5};
    v[3] = '{16'h7C01, 16'h3C00, 1'b0, 16'h7E00, 4'h8};
    v[4] = '{16'h3C00, 16'h7E00, 1'b0, 16'h7E00, 4'h0};
    v[5] = '{16'hFC00, 16'h4000, 1'b0, 16'hFC00, 4'h0};
    v[6] = '{16'h3FFF, 16'h3FFF, 1'b0, 16'h43FE, 4'h1};
    for (int i = 0; i < 7; i++) begin
      send_one(v[i].a, v[i].b, v[i].r);
      wait_out(r, f, lat);
      checks++;
      if (lat == 0 || r !== v[i].res || f !== v[i].flg) begin
        errors++;
        $display("FAIL special_%0d: got res=%h flg=%h lat=%0d, required res=%h flg=%h",
                 i, r, f, lat, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_underflow();
    logic [15:0] r; logic [3:0] f; int lat;
    vec_t v[2];
    v[0] = '{16'h0400, 16'h0400, 1'b0, 16'h0000, 4'h3};
    v[1] = '{16'h8001, 16'h3C00, 1'b0, 16'h8000, 4'h0};
    for (int i = 0; i < 2; i++) begin
      send_one(v[i].a, v[i].b, v[i].r);
      wait_out(r, f, lat);
      checks++;
      if (lat == 0 || r !== v[i].res || f !== v[i].flg) begin
        errors++;
        $display("FAIL underflow_%0d: got res=%h flg=%h lat=%0d, required res=%h flg=%h",
                 i, r, f, lat, v[i].res, v[i].flg);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int outs = 0;
    logic hold = 1'b0;
    logic [LANES-1:0][W-1:0] prev_res;
    logic [LANES-1:0][3:0]   prev_flg;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      ready_i = !(c >= 2 && c <= 6);
      valid_i = (sent < 8);
      rm      = 1'($urandom);
      for (int l = 0; l < LANES; l++) begin
        operands[l][0] = rand_op();
        operands[l][1] = rand_op();
      end
      @(negedge clk);
      if (hold) begin
        checks++;
        if (valid_o !== 1'b1 || result !== prev_res || flags !== prev_flg) begin
          errors++;
          $display("FAIL b2b_frozen: got valid=%b res=%h, required 1 res=%h", valid_o, result, prev_res);
        end
      end
      if (valid_o && !ready_i) begin
        checks++;
        if (ready_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b_stall_ready: got ready_o=%b, required 0", ready_o);
        end
      end
      hold     = valid_o && !ready_i;
      prev_res = result;
      prev_flg = flags;
      if (valid_i && ready_o) sent++;
      if (valid_o && ready_i) outs++;
      if (sent == 8 && outs == 8) break;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sent != 8 || outs != 8) begin
      errors++;
      $display("FAIL b2b_count: got sent=%0d out=%0d, required 8/8", sent, outs);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_pending: got %0d outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      rm      = 1'($urandom);
      for (int l = 0; l < LANES; l++) begin
        operands[l][0] = rand_op();
        operands[l][1] = rand_op();
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < 20 && sb_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain: got %0d outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      valid_i = 1'b1;
      ready_i = 1'b1;
      rm      = 1'($urandom);
      for (int l = 0; l < LANES; l++) begin
        operands[l][0] = rand_op();
        operands[l][1] = rand_op();
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b1) begin
      errors++;
      $display("FAIL midflight_pre: got valid_o=%b, required 1", valid_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || result !== '0 || flags !== '0) begin
      errors++;
      $display("FAIL midflight_reset: got valid=%b res=%h flg=%h, required 0/0/0", valid_o, result, flags);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (valid_o) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midflight_ghost: got %0d valid cycles after release, required 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_underflow();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
